vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Pixel-timing master for the HDMI/VGA video path; the pixel-clock-side counterpart to the pattern/pixel sources.
- Generates the `o_rd`, `o_newline` and `o_newframe` strobes that pixel sources consume, and accepts their registered pixel one clock later.
- Drives horizontal sync, vertical sync, data-enable and RGB, aligned for the TMDS encoder stage.
- Horizontal and vertical mode values are latched only at frame boundaries, so mode changes never tear a frame.

Parameters:
- BITS_PER_COLOR, 4, bits per colour channel; BPP = 3*BITS_PER_COLOR.
- HW, 12, width of horizontal counters and horizontal mode inputs.
- VW, 12, width of vertical counters and vertical mode inputs.

Ports:
- i_pixclk  in  1  pixel clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_hm_width  in  HW  active pixels per line.
- i_hm_porch  in  HW  hpos where hsync asserts.
- i_hm_synch  in  HW  hpos where hsync deasserts.
- i_hm_raw  in  HW  total clocks per line.
- i_vm_height  in  VW  active lines per frame.
- i_vm_porch  in  VW  vsync start line.
- i_vm_synch  in  VW  vsync end line.
- i_vm_raw  in  VW  total lines per frame.
- i_pixel  in  BPP  pixel from source, valid the cycle after o_rd.
- o_rd  out  1  pixel request.
- o_newline  out  1  end-of-line strobe.
- o_newframe  out  1  end-of-frame strobe.
- o_width  out  HW  latched active width.
- o_height  out  VW  latched active height.
- o_vga_hsync  out  1  horizontal sync, active low.
- o_vga_vsync  out  1  vertical sync, active low.
- o_vga_de  out  1  data enable.
- o_vga_red  out  BITS_PER_COLOR  red channel.
- o_vga_green  out  BITS_PER_COLOR  green channel.
- o_vga_blue  out  BITS_PER_COLOR  blue channel.

Behaviour:
- Reset and output reset values:
  - Reset is synchronous, active-high, on i_pixclk.
  - On reset: hpos=0, vpos=0, all mode inputs latched into shadow registers.
  - Output reset values: o_vga_hsync=1, o_vga_vsync=1, o_vga_de=0, RGB=0, o_width/o_height = latched width/height.
  - Reset mid-frame aborts the frame immediately; the next cycle restarts at (0,0).
- Mode validity (computed from latched values): W>0, W<=porch<=synch<raw, and the same ordering vertically.
- INVALID state (mode invalid):
  - Counters held at 0; o_rd=0; o_newline=1 and o_newframe=1 continuously, which holds sources in reset.
  - Outputs blanked: syncs high, DE=0, RGB=0.
  - Modes re-latched every cycle; RUN is entered the cycle after a valid latch.
- RUN state, counters:
  - hpos increments each clock and wraps to 0 at raw-1.
  - vpos increments when hpos==raw-1 and wraps to 0 at vraw-1.
- RUN state, strobes (combinational from the registered counters, cycle t):
  - o_rd = (hpos<W) && (vpos<H).
  - o_newline = (hpos==raw-1).
  - o_newframe = o_newline && (vpos==vraw-1).
- Mode latch: shadow modes re-latch only in the o_newframe cycle. If the new mode is invalid, the block enters INVALID next cycle.
- Output pipeline:
  - Stage 1 (edge ending cycle t): de1<=o_rd; hs1<=!(porch<=hpos<synch); vs1<=!(vporch<=vpos<vsynch).
  - Stage 2 (edge ending t+1): o_vga_de<=de1; syncs<=hs1/vs1; RGB<=de1 ? i_pixel split {R,G,B} MSB-first : 0.
  - o_rd-to-o_vga_de latency is 2 clocks; syncs share the same latency.
- Width rules: all comparisons unsigned at HW/VW. raw=0 or W=0 is invalid by rule.
- Simultaneous events: o_newframe always coincides with o_newline. The last active pixel and o_newline never coincide, because W<raw is required by the validity rule.

Test Plan:
- Small valid mode (W=4, porch=5, synch=6, raw=8; H=3, vporch=4, vsynch=5, vraw=6), release reset -> o_rd high for hpos 0..3 on lines 0..2; o_newline at hpos 7; o_newframe every 48 clocks; hsync low 1 clock per line; vsync low for line 4 (8 clocks).
- Same mode, source returns pixel=hpos+1 one cycle after o_rd -> o_vga_de high exactly 2 clocks after o_rd; RGB sequence 1,2,3,4; RGB=0 whenever DE=0.
- Change i_hm_width to 2 mid-frame -> current frame keeps 4 active pixels/line; next frame (after o_newframe) has 2; o_width updates in the cycle after o_newframe.
- Set porch=9 > raw=8 -> INVALID: o_rd=0, o_newline=o_newframe=1, syncs high; restore porch=5 -> first o_rd two cycles later at (0,0).
- Assert reset at hpos=3, vpos=1 for one clock -> next cycle hpos=0, vpos=0; syncs high and DE=0 for the two pipeline clocks.
- Max-width counters (raw=4095, W=4094) -> hpos wraps cleanly with no overflow; o_newline at hpos 4094.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Pixel-clock timing master: line/frame counters, source strobes and the
// two-stage sync/DE/RGB output pipeline feeding the TMDS encoder.
module vga_timing_gen #(
    parameter int unsigned BITS_PER_COLOR = 4,
    parameter int unsigned HW             = 12,
    parameter int unsigned VW             = 12
) (
    input  logic                          i_pixclk,
    input  logic                          i_reset,
    input  logic [HW-1:0]                 i_hm_width,
    input  logic [HW-1:0]                 i_hm_porch,
    input  logic [HW-1:0]                 i_hm_synch,
    input  logic [HW-1:0]                 i_hm_raw,
    input  logic [VW-1:0]                 i_vm_height,
    input  logic [VW-1:0]                 i_vm_porch,
    input  logic [VW-1:0]                 i_vm_synch,
    input  logic [VW-1:0]                 i_vm_raw,
    input  logic [3*BITS_PER_COLOR-1:0]   i_pixel,
    output logic                          o_rd,
    output logic                          o_newline,
    output logic                          o_newframe,
    output logic [HW-1:0]                 o_width,
    output logic [VW-1:0]                 o_height,
    output logic                          o_vga_hsync,
    output logic                          o_vga_vsync,
    output logic                          o_vga_de,
    output logic [BITS_PER_COLOR-1:0]     o_vga_red,
    output logic [BITS_PER_COLOR-1:0]     o_vga_green,
    output logic [BITS_PER_COLOR-1:0]     o_vga_blue
);

    localparam int unsigned BPP = 3 * BITS_PER_COLOR;

    typedef enum logic {
        ST_INVALID = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t        state;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;

    // Shadow copies of the mode inputs; only these drive the timing.
    logic [HW-1:0] sh_width;
    logic [HW-1:0] sh_porch;
    logic [HW-1:0] sh_synch;
    logic [HW-1:0] sh_raw;
    logic [VW-1:0] sh_height;
    logic [VW-1:0] sh_vporch;
    logic [VW-1:0] sh_vsynch;
    logic [VW-1:0] sh_vraw;

    logic          in_ok;
    logic          sh_ok;
    logic          line_end;
    logic          frame_end;
    logic          latch_en;

    logic          de1;
    logic          hs1;
    logic          vs1;

    function automatic logic h_mode_ok(
        input logic [HW-1:0] width,
        input logic [HW-1:0] porch,
        input logic [HW-1:0] synch,
        input logic [HW-1:0] raw
    );
        return (width != '0) && (width <= porch) && (porch <= synch) && (synch < raw);
    endfunction

    function automatic logic v_mode_ok(
        input logic [VW-1:0] height,
        input logic [VW-1:0] porch,
        input logic [VW-1:0] synch,
        input logic [VW-1:0] raw
    );
        return (height != '0) && (height <= porch) && (porch <= synch) && (synch < raw);
    endfunction

    // Validity of the incoming mode and of the currently latched one.
    always_comb begin
        in_ok = h_mode_ok(i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw)
             && v_mode_ok(i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw);
        sh_ok = h_mode_ok(sh_width, sh_porch, sh_synch, sh_raw)
             && v_mode_ok(sh_height, sh_vporch, sh_vsynch, sh_vraw);
    end

    // Source strobes; an invalid mode parks the sources in their reset.
    always_comb begin
        line_end   = 1'b0;
        frame_end  = 1'b0;
        o_rd       = 1'b0;
        o_newline  = 1'b1;
        o_newframe = 1'b1;
        if (state == ST_RUN) begin
            line_end   = (hpos == HW'(sh_raw - HW'(1)));
            frame_end  = line_end && (vpos == VW'(sh_vraw - VW'(1)));
            o_rd       = (hpos < sh_width) && (vpos < sh_height);
            o_newline  = line_end;
            o_newframe = frame_end;
        end
    end

    assign latch_en = i_reset || o_newframe;
    assign o_width  = sh_width;
    assign o_height = sh_height;

    // Mode shadows move only at frame boundaries (or every cycle while invalid).
    always_ff @(posedge i_pixclk) begin
        if (latch_en) begin
            sh_width  <= i_hm_width;
            sh_porch  <= i_hm_porch;
            sh_synch  <= i_hm_synch;
            sh_raw    <= i_hm_raw;
            sh_height <= i_vm_height;
            sh_vporch <= i_vm_porch;
            sh_vsynch <= i_vm_synch;
            sh_vraw   <= i_vm_raw;
        end
    end

    // Run/invalid control and the raster counters.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state <= in_ok ? ST_RUN : ST_INVALID;
            hpos  <= '0;
            vpos  <= '0;
        end else begin
            case (state)
                ST_INVALID: begin
                    hpos  <= '0;
                    vpos  <= '0;
                    state <= sh_ok ? ST_RUN : ST_INVALID;
                end
                ST_RUN: begin
                    if (line_end) begin
                        hpos <= '0;
                        vpos <= frame_end ? '0 : VW'(vpos + VW'(1));
                    end else begin
                        hpos <= HW'(hpos + HW'(1));
                    end
                    if (frame_end) begin
                        state <= in_ok ? ST_RUN : ST_INVALID;
                    end
                end
                default: begin
                    hpos  <= '0;
                    vpos  <= '0;
                    state <= ST_INVALID;
                end
            endcase
        end
    end

    // Two-stage output pipeline: stage 1 waits for the source's registered pixel.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            de1         <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            o_vga_de    <= 1'b0;
            o_vga_hsync <= 1'b1;
            o_vga_vsync <= 1'b1;
            o_vga_red   <= '0;
            o_vga_green <= '0;
            o_vga_blue  <= '0;
        end else begin
            de1 <= o_rd;
            hs1 <= !((state == ST_RUN) && (hpos >= sh_porch) && (hpos < sh_synch));
            vs1 <= !((state == ST_RUN) && (vpos >= sh_vporch) && (vpos < sh_vsynch));

            o_vga_de    <= de1;
            o_vga_hsync <= hs1;
            o_vga_vsync <= vs1;
            if (de1) begin
                o_vga_red   <= i_pixel[BPP-1                  -: BITS_PER_COLOR];
                o_vga_green <= i_pixel[2*BITS_PER_COLOR-1      -: BITS_PER_COLOR];
                o_vga_blue  <= i_pixel[BITS_PER_COLOR-1        -: BITS_PER_COLOR];
            end else begin
                o_vga_red   <= '0;
                o_vga_green <= '0;
                o_vga_blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: raster strobes, output pipeline,
// frame-boundary mode latching, invalid modes, mid-frame reset and max width.
module tb_vga_timing_gen;

    localparam int unsigned BPC = 4;
    localparam int unsigned HW  = 12;
    localparam int unsigned VW  = 12;
    localparam int unsigned BPP = 3 * BPC;

    logic           clk = 1'b0;
    logic           rst;
    logic [HW-1:0]  hm_width, hm_porch, hm_synch, hm_raw;
    logic [VW-1:0]  vm_height, vm_porch, vm_synch, vm_raw;
    logic [BPP-1:0] pixel;
    logic           rd, newline, newframe;
    logic [HW-1:0]  width;
    logic [VW-1:0]  height;
    logic           hsync, vsync, de;
    logic [BPC-1:0] red, green, blue;

    always #5 clk = ~clk;

    vga_timing_gen #(.BITS_PER_COLOR(BPC), .HW(HW), .VW(VW)) dut (
        .i_pixclk    (clk),
        .i_reset     (rst),
        .i_hm_width  (hm_width),
        .i_hm_porch  (hm_porch),
        .i_hm_synch  (hm_synch),
        .i_hm_raw    (hm_raw),
        .i_vm_height (vm_height),
        .i_vm_porch  (vm_porch),
        .i_vm_synch  (vm_synch),
        .i_vm_raw    (vm_raw),
        .i_pixel     (pixel),
        .o_rd        (rd),
        .o_newline   (newline),
        .o_newframe  (newframe),
        .o_width     (width),
        .o_height    (height),
        .o_vga_hsync (hsync),
        .o_vga_vsync (vsync),
        .o_vga_de    (de),
        .o_vga_red   (red),
        .o_vga_green (green),
        .o_vga_blue  (blue)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Expected raster position and latched mode.
    int bw, bp, bs, br, bh, bvp, bvs, bvr;
    int eh, ev, eh_d1;
    bit exp_inv;
    bit de_d1, de_d2, hs_d1, hs_d2, vs_d1, vs_d2, rd_d1;
    logic [BPP-1:0] pix_d1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, eh, ev);
        end
    endtask

    function automatic bit mode_valid(input int w, input int p, input int s, input int r);
        return (w > 0) && (w <= p) && (p <= s) && (s < r);
    endfunction

    function automatic logic [BPP-1:0] pix_of(input int h);
        return {4'(h + 1), 4'(h + 2), 4'(h + 3)};
    endfunction

    task automatic latch_model();
        bw  = int'(hm_width);  bp  = int'(hm_porch); bs  = int'(hm_synch); br  = int'(hm_raw);
        bh  = int'(vm_height); bvp = int'(vm_porch); bvs = int'(vm_synch); bvr = int'(vm_raw);
    endtask

    task automatic reset_model();
        latch_model();
        exp_inv = !(mode_valid(bw, bp, bs, br) && mode_valid(bh, bvp, bvs, bvr));
        eh = 0; ev = 0; eh_d1 = 0;
        de_d1 = 0; de_d2 = 0; rd_d1 = 0;
        hs_d1 = 1; hs_d2 = 1; vs_d1 = 1; vs_d2 = 1;
        pix_d1 = '0;
    endtask

    // Check one pixel clock against the expected raster, then advance one clock.
    task automatic cycle();
        bit x_rd, x_nl, x_nf, x_hs, x_vs;
        logic [BPP-1:0] p;
        if (exp_inv) begin
            x_rd = 0; x_nl = 1; x_nf = 1; x_hs = 1; x_vs = 1;
        end else begin
            x_rd = (eh < bw) && (ev < bh);
            x_nl = (eh == br - 1);
            x_nf = x_nl && (ev == bvr - 1);
            x_hs = !((eh >= bp) && (eh < bs));
            x_vs = !((ev >= bvp) && (ev < bvs));
        end
        chk("rd",       32'(rd),       32'(x_rd));
        chk("newline",  32'(newline),  32'(x_nl));
        chk("newframe", 32'(newframe), 32'(x_nf));
        chk("width",    32'(width),    32'(bw));
        chk("height",   32'(height),   32'(bh));
        chk("de",       32'(de),       32'(de_d2));
        chk("hsync",    32'(hsync),    32'(hs_d2));
        chk("vsync",    32'(vsync),    32'(vs_d2));
        chk("rgb",      32'({red, green, blue}), de_d2 ? 32'(pix_d1) : 32'd0);

        // Source answers one clock after o_rd; junk otherwise so blanking is visible.
        p = rd_d1 ? pix_of(eh_d1) : 12'hFFF;
        pixel = p;

        de_d2 = de_d1; de_d1 = x_rd;
        hs_d2 = hs_d1; hs_d1 = x_hs;
        vs_d2 = vs_d1; vs_d1 = x_vs;
        pix_d1 = p; rd_d1 = x_rd; eh_d1 = eh;

        if (exp_inv) begin
            eh = 0; ev = 0;
            latch_model();
        end else if (x_nl) begin
            eh = 0;
            if (x_nf) begin
                ev = 0;
                latch_model();
                exp_inv = !(mode_valid(bw, bp, bs, br) && mode_valid(bh, bvp, bvs, bvr));
            end else begin
                ev++;
            end
        end else begin
            eh++;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        reset_model();
    endtask

    task automatic set_mode_a();
        hm_width = 12'd4; hm_porch = 12'd5; hm_synch = 12'd6; hm_raw = 12'd8;
        vm_height = 12'd3; vm_porch = 12'd4; vm_synch = 12'd5; vm_raw = 12'd6;
    endtask

    initial begin
        rst = 1'b1;
        pixel = '0;
        set_mode_a();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset values while reset is held.
        chk("rst_hsync",  32'(hsync), 32'd1);
        chk("rst_vsync",  32'(vsync), 32'd1);
        chk("rst_de",     32'(de),    32'd0);
        chk("rst_rgb",    32'({red, green, blue}), 32'd0);
        chk("rst_width",  32'(width),  32'd4);
        chk("rst_height", 32'(height), 32'd3);

        reset_model();
        rst = 1'b0;

        // Two full frames of the small mode (48 clocks each).
        repeat (96) cycle();

        // Width change mid-frame takes effect only at the next frame.
        repeat (20) cycle();
        hm_width = 12'd2;
        repeat (100) cycle();

        // Porch beyond raw drives the block invalid at the frame boundary.
        hm_width = 12'd4;
        hm_porch = 12'd9;
        repeat (120) if (!exp_inv) cycle();
        repeat (5) cycle();
        hm_porch = 12'd5;
        repeat (2) cycle();
        exp_inv = 1'b0;
        repeat (60) cycle();

        // One-clock reset at hpos=3, vpos=1.
        repeat (60) if (!(eh == 3 && ev == 1)) cycle();
        do_reset();
        repeat (60) cycle();

        // Maximum-width line: wrap at 4094 without overflow.
        hm_width = 12'd4094; hm_porch = 12'd4094; hm_synch = 12'd4094; hm_raw = 12'd4095;
        vm_height = 12'd1; vm_porch = 12'd1; vm_synch = 12'd1; vm_raw = 12'd2;
        do_reset();
        repeat (2 * 4095 + 20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
